mil1553_tx_burst: RTL and testbench
===================================

Name: mil1553_tx_burst

Overview:
Parametrised MIL-STD-1553 word transmitter, the next generation of the single-word MIL_1553 TX path. Buffers up to FIFO_DEPTH words, each tagged command/status (CW) or data (DW). Sends each word as Manchester-II bipolar TXP/TXN: sync, 16 data bits MSB first, then parity. Back-to-back words in a burst are contiguous; an enforced idle gap follows each burst.

Parameters:
CLK_PER_BIT, 50, clk cycles per 1553 bit time (1 us at 50 MHz); must be even and >= 4; half-bit HB = CLK_PER_BIT/2.
FIFO_DEPTH, 4, word buffer depth, power of two, >= 2.
GAP_BITS, 4, idle bit times forced after a burst ends; 0 = no gap.
ODD_PARITY, 1, 1 = odd parity (1553 standard), 0 = even (test mode).

Ports:
clk  in  1  single system clock (rising edge).
rst  in  1  synchronous reset, active-high.
wr_en  in  1  push {wr_cw, wr_dat} into FIFO.
wr_dat  in  16  word payload.
wr_cw  in  1  1 = command/status sync, 0 = data sync.
full  out  1  FIFO full (registered).
level  out  $clog2(FIFO_DEPTH+1)  words currently buffered.
ovf  out  1  one-cycle pulse: write dropped because full.
TXP  out  1  positive Manchester line.
TXN  out  1  negative line; complement of TXP while active, 0 while idle.
busy  out  1  high in SYNC/DATA/PARITY/GAP.
word_done  out  1  one-cycle pulse on the last cycle of each word's parity bit.

Behaviour:
- Reset: FIFO flushed, level=0, full=0, ovf=0, TXP=TXN=0, busy=0, word_done=0, FSM=IDLE, counters 0. Reset mid-word aborts immediately; lines idle on the next edge; no partial word resumes.
- Word frame = 20 bit times = 40 half-bits. CW sync: TXP=1 for 3 HB, then 0 for 3 HB. DW sync: TXP=0 for 3 HB, then 1 for 3 HB. Data bit 1: TXP=1 first HB, 0 second HB; bit 0 the inverse. Parity bit: ~^dat when ODD_PARITY=1, else ^dat; encoded like a data bit.
- FSM: IDLE -> SYNC when FIFO non-empty (pop that cycle). SYNC (6 HB) -> DATA (32 HB, bit index 15..0) -> PARITY (2 HB). At the end of PARITY: FIFO non-empty -> SYNC with the next word, zero dead cycles; FIFO empty -> GAP (GAP_BITS*CLK_PER_BIT cycles, lines 0), or straight to IDLE if GAP_BITS=0. GAP -> IDLE. Words written during GAP wait; no start before GAP expires.
- Latency: wr_en into an empty FIFO while IDLE at edge N -> level=1 after N; pop at N+1; first active TXP/TXN value after edge N+2.
- HB counter counts 0..HB-1, then advances the half-bit index. Every half-bit lasts exactly HB cycles; no drift across words.
- FIFO: write while full is dropped and ovf pulses, even if a pop occurs the same cycle. A simultaneous write and pop when not full leaves level unchanged. Pop only occurs at the IDLE->SYNC or PARITY->SYNC transition.
- word_done is asserted on the final cycle of PARITY; busy drops on the first cycle back in IDLE.
- TXP and TXN are registered outputs, glitch-free; never both 1.

Decomposition:
- Package mil1553_pkg: FSM state enum (IDLE, SYNC, DATA, PARITY, GAP); constants SYNC_HB=6, DATA_BITS=16, WORD_HB=40.
- Sub-module mil1553_tx_fifo (parametrised synchronous FIFO, width 17, depth FIFO_DEPTH, outputs full/level/empty). The encoder FSM stays in the top module.

Test Plan:
- Single CW 0x1234, CLK_PER_BIT=50 -> TXP high 75 cyc, low 75 cyc; bits 0001_0010_0011_0100 Manchester; parity 0 (five ones); word_done 1000 cycles after the first active edge; then 200 idle cycles in GAP; busy low after that.
- CW 0x1234 then DW 0x5678 written back-to-back -> contiguous 2000-cycle burst; DW sync low-then-high with no idle cycle between words; DW parity 1 (eight ones).
- Fill the FIFO with 4 words, then a 5th write -> ovf pulse, level stays 4; all 4 words are sent in order; the dropped word is never transmitted.
- Assert rst at cycle 300 of a word -> next edge TXP=TXN=0, level=0, busy=0; a new write afterwards transmits cleanly from sync.
- Write during GAP -> transmission starts exactly GAP_BITS*CLK_PER_BIT cycles after the previous word_done plus 1.
- ODD_PARITY=0, CLK_PER_BIT=4, DW 0xFFFF -> parity bit 0, HB=2 cycles, 80-cycle word; TXN == ~TXP throughout every active cycle.

Source files
------------

// File: rtl/mil1553_pkg.sv
// Shared state encoding and framing constants for the 1553 burst transmitter.
package mil1553_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} tx_state_t;

    localparam int SYNC_HB   = 6;
    localparam int DATA_BITS = 16;
    localparam int WORD_HB   = 40;
    localparam int WORD_W    = DATA_BITS + 1;

    function automatic logic parity_of(input logic [15:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/mil1553_tx_fifo.sv
// Word buffer: {cw, data} entries, registered full flag and level count.
module mil1553_tx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             full_q, full_d, ovf_q, ovf_d;
    logic             push, pop;

    // A write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        push   = wr_en_i && !full_q;
        pop    = rd_en_i && (lvl_q != '0);
        wp_d   = push ? wp_q + AW'(1) : wp_q;
        rp_d   = pop ? rp_q + AW'(1) : rp_q;
        lvl_d  = lvl_q + LW'(push) - LW'(pop);
        full_d = (lvl_d == LW'(DEPTH));
        ovf_d  = wr_en_i && full_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q   <= '0;
            rp_q   <= '0;
            lvl_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            lvl_q  <= lvl_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign rd_data_o = mem_q[rp_q];
    assign full_o    = full_q;
    assign empty_o   = (lvl_q == '0);
    assign level_o   = lvl_q;
    assign ovf_o     = ovf_q;
endmodule

// File: rtl/mil1553_tx_burst.sv
// MIL-STD-1553 burst transmitter: FIFO-fed Manchester-II encoder with
// contiguous words inside a burst and a forced idle gap afterwards.
module mil1553_tx_burst
    import mil1553_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_BITS    = 4,
    parameter bit ODD_PARITY  = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [15:0]                     wr_dat,
    input  logic                            wr_cw,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                            ovf,
    output logic                            TXP,
    output logic                            TXN,
    output logic                            busy,
    output logic                            word_done
);
    localparam int HB       = CLK_PER_BIT / 2;
    localparam int HW       = $clog2(HB);
    localparam int GAP_CYC  = GAP_BITS * CLK_PER_BIT;
    localparam int GW       = $clog2(GAP_CYC + 2);
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    tx_state_t         state_q, state_d;
    logic [HW-1:0]     hb_q, hb_d;
    logic [5:0]        idx_q, idx_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [WORD_W-1:0] word_q, word_d, fifo_rd;
    logic              txp_q, txn_q, done_q, done_d;
    logic              pop, fifo_empty, hb_end, active, line, par;
    logic [4:0]        dpos;

    mil1553_tx_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_data_i ({wr_cw, wr_dat}),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd),
        .full_o    (full),
        .empty_o   (fifo_empty),
        .level_o   (level),
        .ovf_o     (ovf)
    );

    assign hb_end = (hb_q == HW'(HB - 1));
    assign active = (state_q == SYNC) || (state_q == DATA) || (state_q == PARITY);

    // idx_q runs 0..39 across the whole word: sync, data pairs, parity pair.
    always_comb begin
        state_d = state_q;
        hb_d    = hb_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        word_d  = word_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        if (active) begin
            hb_d = hb_end ? '0 : hb_q + HW'(1);
            if (hb_end) idx_d = idx_q + 6'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_rd;
                    state_d = SYNC;
                    hb_d    = '0;
                    idx_d   = '0;
                end
            end
            SYNC: begin
                if (hb_end && idx_q == 6'(SYNC_HB - 1)) state_d = DATA;
            end
            DATA: begin
                if (hb_end && idx_q == 6'(SYNC_HB + 2*DATA_BITS - 1)) state_d = PARITY;
            end
            PARITY: begin
                if (hb_end && idx_q == 6'(WORD_HB - 1)) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        word_d  = fifo_rd;
                        state_d = SYNC;
                    end else if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dpos = 5'(idx_q - 6'(SYNC_HB));
        par  = parity_of(word_q[15:0], ODD_PARITY);
        line = 1'b0;
        unique case (state_q)
            SYNC:    line = word_q[16] ? (idx_q < 6'(SYNC_HB/2)) : (idx_q >= 6'(SYNC_HB/2));
            DATA:    line = word_q[4'd15 - dpos[4:1]] ^ dpos[0];
            PARITY:  line = par ^ idx_q[0];
            default: line = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hb_q    <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            txp_q   <= 1'b0;
            txn_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            txp_q   <= active & line;
            txn_q   <= active & ~line;
            done_q  <= done_d;
        end
    end

    assign TXP       = txp_q;
    assign TXN       = txn_q;
    assign busy      = (state_q != IDLE);
    assign word_done = done_q;
endmodule

// File: tb/tb_mil1553_tx_burst.sv
// Bench for mil1553_tx_burst: line decoder + scoreboard, table and corner cases.
module tb_mil1553_tx_burst;
    typedef struct packed { logic cw; logic [15:0] dat; logic par; } exp_t;
    typedef struct { logic cw; logic [15:0] dat; logic par; } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en_a = 1'b0, wr_cw_a = 1'b0, wr_en_f = 1'b0, wr_cw_f = 1'b0;
    logic [15:0] wr_dat_a = '0, wr_dat_f = '0;
    logic        full_a, ovf_a, txp_a, txn_a, busy_a, done_a;
    logic        full_f, ovf_f, txp_f, txn_f, busy_f, done_f;
    logic [2:0]  level_a, level_f;

    exp_t sb_a[$], sb_f[$];
    int   st_a[$], st_f[$];
    int   cyc = 0, checks = 0, errors = 0;
    bit   abort = 1'b0;
    vec_t tbl[5];

    mil1553_tx_burst u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_dat(wr_dat_a), .wr_cw(wr_cw_a),
        .full(full_a), .level(level_a), .ovf(ovf_a), .TXP(txp_a), .TXN(txn_a),
        .busy(busy_a), .word_done(done_a)
    );

    mil1553_tx_burst #(.CLK_PER_BIT(4), .ODD_PARITY(1'b0)) u_fast (
        .clk(clk), .rst(rst), .wr_en(wr_en_f), .wr_dat(wr_dat_f), .wr_cw(wr_cw_f),
        .full(full_f), .level(level_f), .ovf(ovf_f), .TXP(txp_f), .TXN(txn_f),
        .busy(busy_f), .word_done(done_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic par_of(input logic [15:0] d, input bit odd);
        int n;
        n = $countones(d);
        return odd ? (n % 2 == 0) : (n % 2 == 1);
    endfunction

    function automatic int sta(input int i);
        return (i < st_a.size()) ? st_a[i] : -100000;
    endfunction

    function automatic int stf(input int i);
        return (i < st_f.size()) ? st_f[i] : -100000;
    endfunction

    function automatic logic lp(input bit f);
        return f ? txp_f : txp_a;
    endfunction

    function automatic logic ln(input bit f);
        return f ? txn_f : txn_a;
    endfunction

    // Decode one 40-half-bit word starting at the current (first active) cycle.
    task automatic decode(input bit f);
        int          hbn;
        bit          hv[40];
        bit          ok, cw;
        logic [15:0] d;
        logic        p, n;
        logic [5:0]  sy;
        exp_t        e;
        string       pre;
        hbn = f ? 2 : 25;
        pre = f ? "fast" : "main";
        ok  = 1'b1;
        cw  = 1'b0;
        d   = '0;
        if (f) st_f.push_back(cyc); else st_a.push_back(cyc);
        for (int h = 0; h < 40; h++) begin
            for (int c = 0; c < hbn; c++) begin
                if (h != 0 || c != 0) begin
                    @(negedge clk);
                    if (abort) return;
                end
                p = lp(f);
                n = ln(f);
                if (n !== ~p) ok = 1'b0;
                if (c == 0) hv[h] = p;
                else if (p !== hv[h]) ok = 1'b0;
            end
        end
        sy = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5]};
        if (sy == 6'b111000) cw = 1'b1;
        else if (sy != 6'b000111) ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d[15-k] = hv[6+2*k];
            if (hv[7+2*k] == hv[6+2*k]) ok = 1'b0;
        end
        if (hv[39] == hv[38]) ok = 1'b0;
        check($sformatf("%s_shape", pre), 32'(ok), 1);
        if (f) begin
            check("fast_sb_pending", 32'(sb_f.size() > 0), 1);
            if (sb_f.size() > 0) begin
                e = sb_f.pop_front();
                check("fast_word", 32'({cw, d, hv[38]}), 32'(e));
            end
        end else begin
            check("main_sb_pending", 32'(sb_a.size() > 0), 1);
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                check("main_word", 32'({cw, d, hv[38]}), 32'(e));
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!abort && !rst && (txp_a || txn_a)) decode(1'b0);
    end

    initial forever begin
        @(negedge clk);
        if (!abort && !rst && (txp_f || txn_f)) decode(1'b1);
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input bit f, input logic cw, input logic [15:0] d,
                      input logic p, input bit push);
        if (f) begin
            wr_en_f = 1'b1; wr_cw_f = cw; wr_dat_f = d;
            if (push) sb_f.push_back(exp_t'({cw, d, p}));
        end else begin
            wr_en_a = 1'b1; wr_cw_a = cw; wr_dat_a = d;
            if (push) sb_a.push_back(exp_t'({cw, d, p}));
        end
        @(negedge clk);
        wr_en_f = 1'b0;
        wr_en_a = 1'b0;
    endtask

    task automatic wait_done(input bit f, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (f ? done_f : done_a) begin
                at = cyc;
                break;
            end
        end
        check("done_seen", 32'(at >= 0), 1);
    endtask

    task automatic wait_idle(input bit f, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (f ? (!busy_f && level_f == 0 && sb_f.size() == 0)
                  : (!busy_a && level_a == 0 && sb_a.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 32'(ok), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int  n, d, b, p;
        bit  quiet;
        tbl[0] = '{1'b1, 16'h1234, 1'b0};
        tbl[1] = '{1'b0, 16'h5678, 1'b1};
        tbl[2] = '{1'b0, 16'hFFFF, 1'b1};
        tbl[3] = '{1'b1, 16'h0001, 1'b0};
        tbl[4] = '{1'b0, 16'hA5A5, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_lines", 32'({txp_a, txn_a, txp_f, txn_f}), 0);
        check("rst_busy", 32'({busy_a, busy_f}), 0);
        check("rst_level", 32'(level_a), 0);
        check("rst_flags", 32'({full_a, ovf_a, done_a}), 0);

        // single CW, latency and gap
        st_a.delete();
        wr(0, tbl[0].cw, tbl[0].dat, tbl[0].par, 1);
        n = cyc;
        check("lat_level", 32'(level_a), 1);
        wait_done(0, 1100, d);
        check("t1_start", 32'(sta(0) - n), 2);
        check("t1_done", 32'(d - n), 1001);
        check("t1_len", 32'(d - sta(0)), 999);
        quiet = 1'b1;
        b = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                b = cyc;
                break;
            end
            if (txp_a || txn_a) quiet = 1'b0;
        end
        check("t1_gap_quiet", 32'(quiet), 1);
        check("t1_gap_len", 32'(b - d), 200);

        // table burst: contiguous words
        st_a.delete();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            wr(0, tbl[i].cw, tbl[i].dat, tbl[i].par, 1);
            if (i == 0) n = cyc;
        end
        wait_idle(0, 7000);
        check("burst_start", 32'(sta(0) - n), 2);
        for (int i = 1; i < 5; i++) check("burst_contig", 32'(sta(i) - sta(i-1)), 1000);

        // overflow
        wr(0, 1'b1, 16'h1111, par_of(16'h1111, 1), 1);
        repeat (3) @(negedge clk);
        wr(0, 1'b0, 16'h2222, par_of(16'h2222, 1), 1);
        wr(0, 1'b1, 16'h0F0F, par_of(16'h0F0F, 1), 1);
        wr(0, 1'b0, 16'h7FFF, par_of(16'h7FFF, 1), 1);
        wr(0, 1'b1, 16'h8000, par_of(16'h8000, 1), 1);
        check("ovf_full", 32'(full_a), 1);
        check("ovf_level", 32'(level_a), 4);
        wr(0, 1'b0, 16'hDEAD, par_of(16'hDEAD, 1), 0);
        check("ovf_pulse", 32'(ovf_a), 1);
        check("ovf_level_hold", 32'(level_a), 4);
        @(negedge clk);
        check("ovf_clear", 32'(ovf_a), 0);
        wait_idle(0, 8000);

        // reset mid-word
        wr(0, 1'b1, 16'h1234, 1'b0, 1);
        n = cyc;
        wr(0, 1'b0, 16'h4444, 1'b0, 1);
        repeat (300) @(negedge clk);
        abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_lines", 32'({txp_a, txn_a}), 0);
        check("mid_rst_level", 32'(level_a), 0);
        check("mid_rst_busy", 32'({busy_a, done_a}), 0);
        sb_a.delete();
        st_a.delete();
        repeat (3) @(negedge clk);
        abort = 1'b0;
        wr(0, 1'b0, 16'h5678, par_of(16'h5678, 1), 1);
        n = cyc;
        wait_idle(0, 2000);
        check("rst_restart", 32'(sta(0) - n), 2);

        // write during gap
        st_a.delete();
        wr(0, 1'b1, 16'h0001, par_of(16'h0001, 1), 1);
        wait_done(0, 1100, d);
        repeat (50) @(negedge clk);
        wr(0, 1'b0, 16'h00FF, par_of(16'h00FF, 1), 1);
        check("gap_wait_level", 32'(level_a), 1);
        p = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (level_a == 0) begin
                p = cyc;
                break;
            end
        end
        check("gap_pop", 32'(p - d), 201);
        wait_idle(0, 2000);
        check("gap_start", 32'(sta(1) - d), 202);

        // fast instance: even parity, HB=2
        st_f.delete();
        wr(1, 1'b0, 16'hFFFF, 1'b0, 1);
        wr(1, 1'b0, 16'h0007, 1'b1, 1);
        wait_done(1, 200, d);
        check("fast_len", 32'(d - stf(0)), 79);
        wait_idle(1, 400);
        check("fast_contig", 32'(stf(1) - stf(0)), 80);

        repeat (5) @(negedge clk);
        check("sb_main_empty", 32'(sb_a.size()), 0);
        check("sb_fast_empty", 32'(sb_f.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
